// File: rtl/cpu_monitor_pkg.sv
// Shared types for the retire monitor: instruction classes, RV opcodes and the trace record layout.
package cpu_monitor_pkg;

    localparam int NUM_CLASSES = 6;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    typedef enum logic [2:0] {
        CLS_OP, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_OPIMM, CLS_OTHER
    } instr_class_e;

    // XLEN-wide fields (pc, wdata) are packed around this by the top
    typedef struct packed {
        logic [31:0]  instr;
        instr_class_e cls;
    } trace_rec_t;

    function automatic instr_class_e classify(input logic [6:0] opc);
        case (opc)
            OPC_OP:     return CLS_OP;
            OPC_LOAD:   return CLS_LOAD;
            OPC_STORE:  return CLS_STORE;
            OPC_BRANCH: return CLS_BRANCH;
            OPC_OPIMM:  return CLS_OPIMM;
            default:    return CLS_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO for trace records; a push on a full FIFO only succeeds alongside a pop.
module trace_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cpu_retire_monitor.sv
// Retire-side monitor: halt FSM, class counters and trace FIFO.
// Define TRACE_WDATA_EN to carry rd/wdata through the trace FIFO.
module cpu_retire_monitor #(
    parameter int XLEN     = 64,
    parameter int DEPTH    = 16,
    parameter int CNT_W    = 32,
    parameter int HALT_RUN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             retire_valid,
    input  logic [XLEN-1:0]  retire_pc,
    input  logic [31:0]      retire_instr,
    input  logic             retire_wen,
    input  logic [4:0]       retire_rd,
    input  logic [XLEN-1:0]  retire_wdata,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [XLEN-1:0]  trace_pc,
    output logic [31:0]      trace_instr,
    output logic [2:0]       trace_class,
    output logic [4:0]       trace_rd,
    output logic [XLEN-1:0]  trace_wdata,
    input  logic [2:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_rdata,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic             overflow
);
    import cpu_monitor_pkg::*;

    typedef enum logic {RUN, HALTED} state_e;
    localparam int SW = $clog2(HALT_RUN + 1);

    state_e           state;
    logic [SW-1:0]    streak;
    logic [CNT_W-1:0] class_cnt [NUM_CLASSES];
    logic [CNT_W-1:0] drop_cnt;
    logic             is_zero, push, pop, full, empty, drop;
    instr_class_e     cls;
    trace_rec_t       rec_in, rec_out;

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign is_zero     = retire_instr == '0;
    assign cls         = classify(retire_instr[6:0]);
    assign push        = (state == RUN) && retire_valid && !is_zero && !clear;
    assign pop         = trace_valid && trace_ready;
    assign drop        = push && full && !pop;
    assign trace_valid = !empty;
    assign halted      = state == HALTED;
    assign rec_in      = '{instr: retire_instr, cls: cls};
    assign trace_instr = rec_out.instr;
    assign trace_class = rec_out.cls;

`ifdef TRACE_WDATA_EN
    localparam int REC_W = 2*XLEN + 5 + $bits(trace_rec_t);
    logic             wr_en;
    logic [REC_W-1:0] fifo_din, fifo_dout;

    // rd == 0 writes are architecturally invisible, so they are recorded as no-writes
    assign wr_en    = retire_wen && (retire_rd != '0);
    assign fifo_din = {retire_pc, rec_in, wr_en ? retire_rd : 5'd0,
                       wr_en ? retire_wdata : {XLEN{1'b0}}};
    assign {trace_pc, rec_out, trace_rd, trace_wdata} = fifo_dout;
`else
    localparam int REC_W = XLEN + $bits(trace_rec_t);
    logic [REC_W-1:0] fifo_din, fifo_dout;
    logic             unused_wb;

    assign unused_wb   = ^{retire_wen, retire_rd, retire_wdata};
    assign fifo_din    = {retire_pc, rec_in};
    assign {trace_pc, rec_out} = fifo_dout;
    assign trace_rd    = '0;
    assign trace_wdata = '0;
`endif

    trace_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || clear) begin
            state       <= RUN;
            streak      <= '0;
            cycle_count <= '0;
            instret     <= '0;
            drop_cnt    <= '0;
            overflow    <= 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++) class_cnt[i] <= '0;
        end else if (state == RUN) begin
            cycle_count <= inc(cycle_count);
            if (retire_valid && is_zero) begin
                if (int'(streak) + 1 >= HALT_RUN) begin
                    state  <= HALTED;
                    streak <= '0;
                end else begin
                    streak <= streak + SW'(1);
                end
            end else if (retire_valid) begin
                streak  <= '0;
                instret <= inc(instret);
                for (int i = 0; i < NUM_CLASSES; i++)
                    if (int'(cls) == i) class_cnt[i] <= inc(class_cnt[i]);
            end
            if (drop) begin
                drop_cnt <= inc(drop_cnt);
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        cnt_rdata = '0;
        case (cnt_sel)
            3'd0:    cnt_rdata = class_cnt[0];
            3'd1:    cnt_rdata = class_cnt[1];
            3'd2:    cnt_rdata = class_cnt[2];
            3'd3:    cnt_rdata = class_cnt[3];
            3'd4:    cnt_rdata = class_cnt[4];
            3'd5:    cnt_rdata = class_cnt[5];
            3'd6:    cnt_rdata = drop_cnt;
            default: cnt_rdata = '0;
        endcase
    end

endmodule
